// File: rtl/cpu_seq_controller.sv
// Multi-cycle instruction sequencer: owns PC, IR and the fetch/decode/exec/mem/wb FSM,
// drives a ready-handshake memory port, datapath strobes, interrupt entry/return and traps.
module cpu_seq_controller #(
  parameter int                WIDTH    = 16,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] IRQ_VEC  = 8'hF0,
  parameter logic [ADDR_W-1:0] TRAP_VEC = 8'hF8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ready,
  input  logic              zero,
  input  logic              irq,
  output logic [WIDTH-1:0]  ir,
  output logic [ADDR_W-1:0] pc,
  output logic              alu_en,
  output logic              reg_we,
  output logic              wb_sel,
  output logic [2:0]        state,
  output logic              instr_done,
  output logic              halted,
  output logic              trap,
  output logic              in_isr
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ALU   = 4'd1,
    OP_LOAD  = 4'd2,
    OP_STORE = 4'd3,
    OP_JUMP  = 4'd4,
    OP_BRZ   = 4'd5,
    OP_RETI  = 4'd6,
    OP_HALT  = 4'd15
  } opcode_t;

  state_t              cur, cur_nx;
  logic [ADDR_W-1:0]   pc_q, pc_nx, epc_q, epc_nx;
  logic [WIDTH-1:0]    ir_q, ir_nx;
  logic                in_isr_q, in_isr_nx, wb_sel_q, wb_sel_nx;
  logic                retire;
  logic                access;
  logic [3:0]          opc;
  logic [ADDR_W-1:0]   imm_addr;

  assign opc      = ir_q[WIDTH-1 -: 4];
  assign imm_addr = ADDR_W'(ir_q[WIDTH-5:0]);

  // NOTE: every target gets a default before the case, so no path can leave one unassigned and infer a latch.
  always_comb begin
    cur_nx     = cur;
    pc_nx      = pc_q;
    epc_nx     = epc_q;
    ir_nx      = ir_q;
    in_isr_nx  = in_isr_q;
    wb_sel_nx  = wb_sel_q;
    retire     = 1'b0;
    access     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc_q;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    trap       = 1'b0;
    halted     = 1'b0;

    case (cur)
      S_FETCH: begin
        access = 1'b1;
        if (mem_ready) begin
          ir_nx  = mem_rdata;
          pc_nx  = pc_q + ADDR_W'(1);
          cur_nx = S_DECODE;
        end
      end
      S_DECODE: cur_nx = S_EXEC;
      S_EXEC: begin
        alu_en = 1'b1;
        cur_nx = S_FETCH;
        case (opc)
          OP_NOP:  retire = 1'b1;
          OP_ALU: begin
            wb_sel_nx = 1'b0;
            cur_nx    = S_WB;
          end
          OP_LOAD, OP_STORE: cur_nx = S_MEM;
          OP_JUMP: begin
            pc_nx  = imm_addr;
            retire = 1'b1;
          end
          OP_BRZ: begin
            if (zero) pc_nx = imm_addr;
            retire = 1'b1;
          end
          OP_RETI: begin
            pc_nx     = epc_q;
            in_isr_nx = 1'b0;
            retire    = 1'b1;
          end
          OP_HALT: begin
            cur_nx = S_HALT;
            retire = 1'b1;
          end
          default: begin
            trap  = 1'b1;
            pc_nx = TRAP_VEC;
          end
        endcase
      end
      S_MEM: begin
        access   = 1'b1;
        mem_addr = imm_addr;
        mem_we   = (opc == OP_STORE);
        if (mem_ready) begin
          if (opc == OP_STORE) begin
            retire = 1'b1;
            cur_nx = S_FETCH;
          end else begin
            wb_sel_nx = 1'b1;
            cur_nx    = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
        cur_nx = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (irq && !in_isr_q) begin
          epc_nx    = pc_q;
          pc_nx     = IRQ_VEC;
          in_isr_nx = 1'b1;
          cur_nx    = S_FETCH;
        end
      end
      default: cur_nx = S_FETCH;
    endcase

    // Interrupt boundary: epc captures the post-jump/branch PC; the old in_isr gates nesting,
    // so a RETI retiring with irq still high does not re-enter in the same cycle.
    if (retire && irq && !in_isr_q) begin
      epc_nx    = pc_nx;
      pc_nx     = IRQ_VEC;
      in_isr_nx = 1'b1;
      cur_nx    = S_FETCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur      <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      epc_q    <= '0;
      in_isr_q <= 1'b0;
      wb_sel_q <= 1'b0;
    end else begin
      cur      <= cur_nx;
      pc_q     <= pc_nx;
      ir_q     <= ir_nx;
      epc_q    <= epc_nx;
      in_isr_q <= in_isr_nx;
      wb_sel_q <= wb_sel_nx;
    end
  end

  // Gating with rst drops the request the instant reset asserts mid-access.
  assign mem_req    = access && rst;
  assign instr_done = retire;
  assign ir         = ir_q;
  assign pc         = pc_q;
  assign wb_sel     = wb_sel_q;
  assign in_isr     = in_isr_q;
  assign state      = cur;

endmodule

// File: tb/tb_cpu_seq_controller.sv
// Directed self-checking bench for cpu_seq_controller: walks a small program through
// every opcode class, memory wait states, interrupt entry/return, trap, halt and reset.
module tb_cpu_seq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ready;
  logic [7:0]  mem_addr, pc;
  logic [15:0] mem_rdata, ir;
  logic        zero, irq;
  logic        alu_en, reg_we, wb_sel, instr_done, halted, trap, in_isr;
  logic [2:0]  state;

  logic [15:0] mem [256];
  int          checks = 0;
  int          errors = 0;

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  cpu_seq_controller dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .zero(zero), .irq(irq), .ir(ir),
    .pc(pc), .alu_en(alu_en), .reg_we(reg_we), .wb_sel(wb_sel), .state(state),
    .instr_done(instr_done), .halted(halted), .trap(trap), .in_isr(in_isr)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1; zero = 1'b0; irq = 1'b0;
    step(); step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h exp 0000", ir); end
    checks++; if ({mem_req, mem_we, wb_sel, in_isr, alu_en, reg_we, instr_done, trap, halted} !== 9'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 000000000",
                         {mem_req, mem_we, wb_sel, in_isr, alu_en, reg_we, instr_done, trap, halted});
    end
    rst = 1'b1;
    #1;
  endtask

  task automatic test_nop();
    checks++; if ({state, mem_req, mem_addr} !== {3'd0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL nop_fetch got st=%0d req=%b addr=%h exp st=0 req=1 addr=00", state, mem_req, mem_addr);
    end
    step();
    checks++; if ({state, pc, ir} !== {3'd1, 8'h01, 16'h0000}) begin
      errors++; $display("FAIL nop_decode got st=%0d pc=%h ir=%h exp st=1 pc=01 ir=0000", state, pc, ir);
    end
    step();
    checks++; if ({state, alu_en, instr_done} !== {3'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL nop_exec got st=%0d alu=%b done=%b exp st=2 alu=1 done=1", state, alu_en, instr_done);
    end
    step();
    checks++; if ({state, pc, instr_done} !== {3'd0, 8'h01, 1'b0}) begin
      errors++; $display("FAIL nop_next got st=%0d pc=%h done=%b exp st=0 pc=01 done=0", state, pc, instr_done);
    end
  endtask

  task automatic test_alu();
    step();
    checks++; if (ir !== 16'h1021) begin errors++; $display("FAIL alu_ir got %h exp 1021", ir); end
    step();
    checks++; if ({state, alu_en, reg_we, instr_done} !== {3'd2, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL alu_exec got st=%0d alu=%b we=%b done=%b exp 2 1 0 0", state, alu_en, reg_we, instr_done);
    end
    step();
    checks++; if ({state, reg_we, wb_sel, instr_done, alu_en} !== {3'd4, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL alu_wb got st=%0d we=%b sel=%b done=%b alu=%b exp 4 1 0 1 0",
                         state, reg_we, wb_sel, instr_done, alu_en);
    end
    step();
    checks++; if ({state, pc} !== {3'd0, 8'h02}) begin
      errors++; $display("FAIL alu_next got st=%0d pc=%h exp st=0 pc=02", state, pc);
    end
  endtask

  task automatic test_load_wait();
    step(); step();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({state, mem_req, mem_we, mem_addr, instr_done} !== {3'd3, 1'b1, 1'b0, 8'h30, 1'b0}) begin
        errors++; $display("FAIL load_mem%0d got st=%0d req=%b we=%b addr=%h done=%b exp 3 1 0 30 0",
                           i, state, mem_req, mem_we, mem_addr, instr_done);
      end
      if (i == 2) mem_ready = 1'b1;
    end
    step();
    checks++; if ({state, reg_we, wb_sel, instr_done} !== {3'd4, 1'b1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL load_wb got st=%0d we=%b sel=%b done=%b exp 4 1 1 1", state, reg_we, wb_sel, instr_done);
    end
    step();
    checks++; if ({state, pc, mem_addr} !== {3'd0, 8'h03, 8'h03}) begin
      errors++; $display("FAIL load_next got st=%0d pc=%h addr=%h exp st=0 pc=03 addr=03", state, pc, mem_addr);
    end
  endtask

  task automatic test_branch();
    zero = 1'b0;
    step(); step();
    checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL brz_nt_done got %b exp 1", instr_done); end
    step();
    checks++; if (pc !== 8'h04) begin errors++; $display("FAIL brz_not_taken_pc got %h exp 04", pc); end
    zero = 1'b1;
    step(); step(); step();
    checks++; if ({state, pc} !== {3'd0, 8'h40}) begin
      errors++; $display("FAIL brz_taken got st=%0d pc=%h exp st=0 pc=40", state, pc);
    end
    zero = 1'b0;
  endtask

  task automatic test_store_jump();
    step(); step(); step();
    checks++; if ({state, mem_req, mem_we, mem_addr, instr_done, reg_we} !== {3'd3, 1'b1, 1'b1, 8'h31, 1'b1, 1'b0}) begin
      errors++; $display("FAIL store_mem got st=%0d req=%b we=%b addr=%h done=%b rwe=%b exp 3 1 1 31 1 0",
                         state, mem_req, mem_we, mem_addr, instr_done, reg_we);
    end
    step();
    checks++; if ({state, pc, mem_we} !== {3'd0, 8'h41, 1'b0}) begin
      errors++; $display("FAIL store_next got st=%0d pc=%h we=%b exp st=0 pc=41 we=0", state, pc, mem_we);
    end
    step(); step(); step();
    checks++; if (pc !== 8'h05) begin errors++; $display("FAIL jump_pc got %h exp 05", pc); end
  endtask

  task automatic test_irq();
    irq = 1'b1;
    step(); step(); step(); step();
    checks++; if ({state, pc, in_isr} !== {3'd0, 8'hF0, 1'b1}) begin
      errors++; $display("FAIL irq_entry got st=%0d pc=%h isr=%b exp st=0 pc=f0 isr=1", state, pc, in_isr);
    end
    step(); step(); step(); step();
    checks++; if ({state, pc, in_isr} !== {3'd0, 8'hF1, 1'b1}) begin
      errors++; $display("FAIL irq_no_nest got st=%0d pc=%h isr=%b exp st=0 pc=f1 isr=1", state, pc, in_isr);
    end
    irq = 1'b0;
    step(); step(); step();
    checks++; if ({state, pc, in_isr} !== {3'd0, 8'h06, 1'b0}) begin
      errors++; $display("FAIL reti got st=%0d pc=%h isr=%b exp st=0 pc=06 isr=0", state, pc, in_isr);
    end
  endtask

  task automatic test_trap_halt();
    step(); step();
    checks++; if ({trap, instr_done, alu_en} !== 3'b101) begin
      errors++; $display("FAIL trap_exec got trap=%b done=%b alu=%b exp 1 0 1", trap, instr_done, alu_en);
    end
    step();
    checks++; if ({state, pc, trap} !== {3'd0, 8'hF8, 1'b0}) begin
      errors++; $display("FAIL trap_vec got st=%0d pc=%h trap=%b exp st=0 pc=f8 trap=0", state, pc, trap);
    end
    step(); step();
    checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL halt_done got %b exp 1", instr_done); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({state, halted, pc, mem_req} !== {3'd5, 1'b1, 8'hF9, 1'b0}) begin
        errors++; $display("FAIL halt_hold%0d got st=%0d halted=%b pc=%h req=%b exp 5 1 f9 0",
                           i, state, halted, pc, mem_req);
      end
    end
    irq = 1'b1;
    step();
    checks++; if ({state, halted, pc, in_isr} !== {3'd0, 1'b0, 8'hF0, 1'b1}) begin
      errors++; $display("FAIL halt_wake got st=%0d halted=%b pc=%h isr=%b exp 0 0 f0 1", state, halted, pc, in_isr);
    end
    irq = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    mem_ready = 1'b0;
    step();
    checks++; if ({state, mem_req, mem_addr} !== {3'd0, 1'b1, 8'hF0}) begin
      errors++; $display("FAIL stall_fetch got st=%0d req=%b addr=%h exp 0 1 f0", state, mem_req, mem_addr);
    end
    mem_ready = 1'b1;
    rst = 1'b0;
    #1;
    checks++; if ({mem_req, pc, in_isr, ir} !== {1'b0, 8'h00, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL reset_mid got req=%b pc=%h isr=%b ir=%h exp 0 00 0 0000", mem_req, pc, in_isr, ir);
    end
    step();
    rst = 1'b1;
    step(); step();
    checks++; if ({state, pc, ir} !== {3'd2, 8'h01, 16'h0000}) begin
      errors++; $display("FAIL restart got st=%0d pc=%h ir=%h exp 2 01 0000", state, pc, ir);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h01] = 16'h1021;
    mem[8'h02] = 16'h2030;
    mem[8'h03] = 16'h5040;
    mem[8'h04] = 16'h5040;
    mem[8'h05] = 16'h1022;
    mem[8'h06] = 16'hA000;
    mem[8'h30] = 16'hBEEF;
    mem[8'h40] = 16'h3031;
    mem[8'h41] = 16'h4005;
    mem[8'hF0] = 16'h1023;
    mem[8'hF1] = 16'h6000;
    mem[8'hF8] = 16'hF000;

    test_reset();
    test_nop();
    test_alu();
    test_load_wait();
    test_branch();
    test_store_jump();
    test_irq();
    test_trap_halt();
    test_reset_mid_fetch();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
